// File: rtl/key_sched_ctrl.sv
// AES-128 round-key sequencer: loads the cipher key, drives an external expandKey
// block once per cycle, and keeps the NR+1 round keys behind a registered read port.
module key_sched_ctrl #(
    parameter int NR = 10,
    parameter int KW = 128,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] key_in,
    output logic [KW-1:0] exp_word,
    output logic [7:0]    exp_count,
    input  logic [KW-1:0] exp_key,
    output logic          busy,
    output logic          done,
    output logic          keys_valid,
    input  logic [IW-1:0] rd_idx,
    input  logic          rd_en,
    output logic [KW-1:0] rd_key
);

    generate
        if (NR < 1 || NR > 255 || (1 << IW) < NR + 1) begin : g_bad_param
            $error("key_sched_ctrl: NR must be 1..255 and 2**IW >= NR+1");
        end
    endgenerate

    localparam logic [0:0]    IDLE     = 1'b0;
    localparam logic [0:0]    EXPAND   = 1'b1;
    localparam logic [7:0]    LAST_CNT = 8'(NR - 1);
    localparam logic [IW-1:0] MAX_IDX  = IW'(NR);

    logic [0:0]    state_q, state_d;
    logic [KW-1:0] word_q, word_d;
    logic [7:0]    count_q, count_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          kv_q, kv_d;
    logic [KW-1:0] rd_key_q;
    logic [KW-1:0] rk_q [0:NR];

    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [KW-1:0] wr_data;
    logic [7:0]    cnt_inc;

    assign cnt_inc = count_q + 8'd1;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        kv_d    = kv_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EXPAND;
                    word_d  = key_in;
                    count_d = 8'd0;
                    kv_d    = 1'b0;
                    busy_d  = 1'b1;
                    wr_en   = 1'b1;
                    wr_data = key_in;
                end
            end
            default: begin
                // Round key count+1 comes back from expandKey in the same cycle.
                wr_en   = 1'b1;
                wr_idx  = IW'(cnt_inc);
                wr_data = exp_key;
                word_d  = exp_key;
                if (count_q == LAST_CNT) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    kv_d    = 1'b1;
                    count_d = 8'd0;
                end else begin
                    count_d = cnt_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            count_q <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            kv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            kv_q    <= kv_d;
        end
    end

    // Store and read port share the edge; the read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
            rd_key_q <= '0;
        end else begin
            if (wr_en) rk_q[wr_idx] <= wr_data;
            if (rd_en) rd_key_q <= (rd_idx <= MAX_IDX) ? rk_q[rd_idx] : '0;
        end
    end

    assign exp_word   = word_q;
    assign exp_count  = count_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = kv_q;
    assign rd_key     = rd_key_q;

endmodule
